// File: rtl/rom_prefetch_pkg.sv
// rtl/rom_prefetch_pkg.sv - shared types and constants for the ROM prefetch buffer
// Contents: fetch FSM state enum, ROM length probe address, FIFO entry layout.
package rom_prefetch_pkg;

    typedef enum logic [1:0] {
        ST_PROBE = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Reading this address returns the ROM length in bytes instead of ROM data.
    localparam logic [63:0] ROM_LEN_ADDR = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [63:0] data;
        logic [63:0] addr;
    } fifo_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - DEPTH-entry synchronous FIFO with flush for prefetched ROM words
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             empties the FIFO (pointers and count cleared)
//   push, push_entry  write one entry at the tail (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   head              head entry, zero when empty
//   valid, full       occupancy flags
//   count             number of stored entries
module prefetch_fifo
    import rom_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fifo_entry_t              push_entry,
    input  logic                     pop,
    output fifo_entry_t              head,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && valid && !flush;

    // Head is forced to zero while empty so stale storage never shows on the outputs.
    assign head = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is masked by valid.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/rom_prefetch_buffer.sv
// rtl/rom_prefetch_buffer.sv - sequential ROM word prefetcher feeding a small FIFO
// Optional feature macro: ROM_PREFETCH_LEN_CHECK_EN (length probe, bounded fetch, eof).
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   en                             fetch enable (pops are independent of en)
//   redirect_valid, redirect_addr  flush FIFO and restart fetch at redirect_addr
//   rom_en, rom_addr, rom_data     combinational ROM read port (byte address, 64-bit word)
//   out_valid, out_ready           head handshake
//   out_data, out_addr             head word and its byte address
//   eof                            fetch reached the ROM length
//   count                          FIFO occupancy
module rom_prefetch_buffer
    import rom_prefetch_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter int unsigned STRIDE     = 8,
    parameter logic [63:0] START_ADDR = 64'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    redirect_valid,
    input  logic [63:0]             redirect_addr,
    output logic                    rom_en,
    output logic [63:0]             rom_addr,
    input  logic [63:0]             rom_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_data,
    output logic [63:0]             out_addr,
    output logic                    eof,
    output logic [$clog2(DEPTH):0]  count
);

    state_t       state;
    state_t       state_nxt;
    logic [63:0]  fetch_addr;
    logic         in_range;
    logic         push;
    logic         pop;
    logic         full;
    fifo_entry_t  wr_entry;
    fifo_entry_t  head;

`ifdef ROM_PREFETCH_LEN_CHECK_EN
    localparam state_t RESET_STATE = ST_PROBE;

    logic [63:0] len_reg;

    assign in_range = (fetch_addr < len_reg);

    // The probe read is independent of redirect, so len_reg only ever loads in PROBE.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg <= '0;
        end else if (state == ST_PROBE) begin
            len_reg <= rom_data;
        end
    end
`else
    localparam state_t RESET_STATE = ST_FETCH;

    assign in_range = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_PROBE: state_nxt = ST_FETCH;
            ST_FETCH: if (!in_range) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = RESET_STATE;
        endcase
        if (redirect_valid) begin
            state_nxt = ST_FETCH;
        end
    end

    // Output logic: the push decision uses count at cycle start, so a full FIFO
    // being popped this cycle still does not accept a new word until next cycle.
    always_comb begin
        rom_en   = 1'b0;
        rom_addr = fetch_addr;
        push     = 1'b0;
        eof      = 1'b0;
        case (state)
            ST_PROBE: begin
                rom_en   = !rst;
                rom_addr = ROM_LEN_ADDR;
            end
            ST_FETCH: begin
                push   = en && !full && in_range && !redirect_valid && !rst;
                rom_en = push;
            end
            ST_DONE: begin
`ifdef ROM_PREFETCH_LEN_CHECK_EN
                eof = 1'b1;
`else
                eof = 1'b0;
`endif
            end
            default: begin
                rom_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr <= START_ADDR;
        end else if (redirect_valid) begin
            fetch_addr <= redirect_addr;
        end else if (push) begin
            fetch_addr <= fetch_addr + 64'(STRIDE);
        end
    end

    assign pop           = out_valid && out_ready && !redirect_valid;
    assign wr_entry.data = rom_data;
    assign wr_entry.addr = fetch_addr;

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (wr_entry),
        .pop        (pop),
        .head       (head),
        .valid      (out_valid),
        .full       (full),
        .count      (count)
    );

    assign out_data = head.data;
    assign out_addr = head.addr;

endmodule
